// File: rtl/serial_ripple_adder_pkg.sv
// Shared types and helpers for the bit-serial ripple adder.
//   state_e   : FSM state encoding (IDLE, SHIFT, DONE)
//   cnt_width : bit-counter width for a given operand width (minimum 1)
package serial_ripple_adder_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      SHIFT = ST_SHIFT,
      DONE  = ST_DONE
   } state_e;

   // A 1-bit operand still needs a 1-bit counter.
   function automatic int unsigned cnt_width(input int unsigned w);
      int unsigned r;
      r = (w <= 32'd1) ? 32'd1 : 32'($clog2(w));
      return r;
   endfunction

endpackage

// File: rtl/serial_ripple_adder_if.sv
// Operand/result handshake bundle for serial_ripple_adder.
//   master : producer/consumer side (drives in_valid, a, b, cin, out_ready)
//   slave  : adder side (drives in_ready, out_valid, sum, cout, busy)
interface serial_ripple_adder_if #(
   parameter int unsigned WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, busy
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, busy
   );
endinterface

// File: rtl/full_adder_half.sv
// Single-bit full-adder slice (purely combinational).
//   a, b, ci : addend bits and carry-in
//   sum_c    : sum bit
//   carry_c  : carry-out
module full_adder_half (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic sum_c,
   output logic carry_c
);
   assign sum_c   = a ^ b ^ ci;
   assign carry_c = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_ripple_adder.sv
// Bit-serial adder: one full-adder slice, carry in a flop, LSB first.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of the operand/result handshake
//                (in_valid/in_ready/a/b/cin in, out_valid/out_ready/sum/cout out, busy)
module serial_ripple_adder
   import serial_ripple_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   serial_ripple_adder_if.slave  bus
);

   localparam int unsigned CW = cnt_width(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             in_ready_q, out_valid_q, busy_q;
   logic             fa_sum, fa_carry;

   full_adder_half u_fa (
      .a       (a_sr_q[0]),
      .b       (b_sr_q[0]),
      .ci      (carry_q),
      .sum_c   (fa_sum),
      .carry_c (fa_carry)
   );

   // Next-state and datapath update
   always_comb begin
      state_d  = state_q;
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      sum_sr_d = sum_sr_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               a_sr_d   = bus.a;
               b_sr_d   = bus.b;
               carry_d  = bus.cin;
               sum_sr_d = '0;
               cnt_d    = '0;
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at bit 0.
            sum_sr_d = (sum_sr_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
            carry_d  = fa_carry;
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, datapath and registered handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_sr_q      <= '0;
         b_sr_q      <= '0;
         sum_sr_q    <= '0;
         carry_q     <= 1'b0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_sr_q      <= a_sr_d;
         b_sr_q      <= b_sr_d;
         sum_sr_q    <= sum_sr_d;
         carry_q     <= carry_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= (state_d == IDLE);
         out_valid_q <= (state_d == DONE);
         busy_q      <= (state_d != IDLE);
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.sum       = sum_sr_q;
   assign bus.cout      = carry_q;

endmodule

// File: tb/tb_serial_ripple_adder.sv
// Directed bench for serial_ripple_adder: an 8-bit and a 1-bit instance.
module tb_serial_ripple_adder;

   logic clk;
   logic rst_n;
   int unsigned checks;
   int unsigned errors;

   serial_ripple_adder_if #(.WIDTH(8)) if8 ();
   serial_ripple_adder_if #(.WIDTH(1)) if1 ();

   serial_ripple_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
   serial_ripple_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic accept8(input logic [7:0] av, input logic [7:0] bv, input logic ci);
      int n;
      n = 0;
      while (!if8.in_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      check("accept_ready", 32'(if8.in_ready), 32'd1);
      @(negedge clk);
      if8.in_valid = 1'b1;
      if8.a        = av;
      if8.b        = bv;
      if8.cin      = ci;
      @(posedge clk); #1;
      if8.in_valid = 1'b0;
   endtask

   task automatic wait_done8(output int n);
      n = 0;
      while (!if8.out_valid && n < 40) begin
         @(posedge clk); #1; n++;
      end
   endtask

   task automatic release8();
      @(negedge clk);
      if8.out_ready = 1'b1;
      @(posedge clk); #1;
      check("release_in_ready", 32'(if8.in_ready), 32'd1);
      check("release_out_valid", 32'(if8.out_valid), 32'd0);
      @(negedge clk);
      if8.out_ready = 1'b0;
   endtask

   logic [7:0] va   [6] = '{8'h5A, 8'hFF, 8'hFF, 8'h0F, 8'h00, 8'hA5};
   logic [7:0] vb   [6] = '{8'h3C, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h5A};
   logic       vc   [6] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b1};
   logic [7:0] vs   [6] = '{8'h96, 8'h00, 8'hFF, 8'h10, 8'h01, 8'h00};
   logic       vco  [6] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1};

   initial begin
      int n;
      int extra;
      logic [7:0] held_sum;
      logic       held_cout;
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0; if8.out_ready = 1'b0;
      if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0; if1.out_ready = 1'b0;

      #12;
      check("rst_in_ready", 32'(if8.in_ready), 32'd1);
      check("rst_out_valid", 32'(if8.out_valid), 32'd0);
      check("rst_sum", 32'(if8.sum), 32'd0);
      check("rst_cout", 32'(if8.cout), 32'd0);
      check("rst_busy", 32'(if8.busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors
      for (int i = 0; i < 6; i++) begin
         accept8(va[i], vb[i], vc[i]);
         check("shift_busy", 32'(if8.busy), 32'd1);
         check("shift_in_ready", 32'(if8.in_ready), 32'd0);
         wait_done8(n);
         check("latency", 32'(n), 32'd8);
         check("sum", 32'(if8.sum), 32'(vs[i]));
         check("cout", 32'(if8.cout), 32'(vco[i]));
         release8();
      end

      // Backpressure: result held while out_ready is low
      accept8(8'h5A, 8'h3C, 1'b0);
      wait_done8(n);
      held_sum  = if8.sum;
      held_cout = if8.cout;
      check("bp_sum", 32'(held_sum), 32'h96);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check("bp_out_valid", 32'(if8.out_valid), 32'd1);
         check("bp_sum_stable", 32'(if8.sum), 32'(held_sum));
         check("bp_cout_stable", 32'(if8.cout), 32'(held_cout));
         check("bp_in_ready", 32'(if8.in_ready), 32'd0);
      end
      release8();
      check("bp_busy_after", 32'(if8.busy), 32'd0);

      // Operand churn during SHIFT, consumer always ready
      accept8(8'h12, 8'h34, 1'b0);
      if8.out_ready = 1'b1;
      n = 0;
      while (!if8.out_valid && n < 40) begin
         @(negedge clk);
         if8.in_valid = 1'b1;
         if8.a        = 8'($urandom);
         if8.b        = 8'($urandom);
         if8.cin      = 1'($urandom);
         @(posedge clk); #1;
         n++;
      end
      if8.in_valid = 1'b0;
      check("churn_latency", 32'(n), 32'd8);
      check("churn_sum", 32'(if8.sum), 32'h46);
      check("churn_cout", 32'(if8.cout), 32'd0);
      extra = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (if8.out_valid) extra++;
      end
      check("churn_single_result", 32'(extra), 32'd0);
      check("churn_idle", 32'(if8.in_ready), 32'd1);
      if8.out_ready = 1'b0;

      // Reset in the middle of SHIFT
      accept8(8'h5A, 8'h3C, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(if8.out_valid), 32'd0);
      check("midrst_in_ready", 32'(if8.in_ready), 32'd1);
      check("midrst_busy", 32'(if8.busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      accept8(8'h80, 8'h80, 1'b0);
      wait_done8(n);
      check("post_rst_latency", 32'(n), 32'd8);
      check("post_rst_sum", 32'(if8.sum), 32'h00);
      check("post_rst_cout", 32'(if8.cout), 32'd1);
      release8();

      // One-bit instance: 1 + 1 + cin 1
      @(negedge clk);
      if1.in_valid = 1'b1;
      if1.a        = 1'b1;
      if1.b        = 1'b1;
      if1.cin      = 1'b1;
      @(posedge clk); #1;
      if1.in_valid = 1'b0;
      check("w1_not_yet_valid", 32'(if1.out_valid), 32'd0);
      check("w1_busy", 32'(if1.busy), 32'd1);
      @(posedge clk); #1;
      check("w1_out_valid", 32'(if1.out_valid), 32'd1);
      check("w1_sum", 32'(if1.sum), 32'd1);
      check("w1_cout", 32'(if1.cout), 32'd1);
      @(negedge clk);
      if1.out_ready = 1'b1;
      @(posedge clk); #1;
      check("w1_release", 32'(if1.in_ready), 32'd1);
      if1.out_ready = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
